ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the Antares 5-stage MIPS pipeline; consumes the ID/EX pipeline register outputs.
//  Resolves EX/MEM and MEM/WB forwarding, runs the ALU, selects the destination register and drives EX/MEM inputs.
//  Owns HI/LO and an iterative 32-cycle multiply/divide unit; stalls upstream stages while that unit is busy.
// PARAMETERS
//  DATA_W   32  datapath width; the iterative unit runs DATA_W steps
// PORTS
//  clock          in   1       clock; all state updates on posedge
//  reset          in   1       synchronous, active-high
//  aluOp          in   4       operation code (encoding in BEHAVIOUR)
//  regDst         in   1       1: writeReg=rd, 0: writeReg=rt
//  aluSrc         in   1       1: operand B=immediate, 0: forwarded B
//  data1, data2   in   DATA_W  register file read data for rs and rt
//  immediate      in   DATA_W  sign-extended immediate; [10:6] is shamt
//  rt, rd         in   5       register specifiers
//  forwardA/B     in   2       00 regfile, 10 exMemResult, 01 memWbResult, 11 regfile
//  exMemResult    in   DATA_W  forwarded value from EX/MEM
//  memWbResult    in   DATA_W  forwarded value from MEM/WB
//  aluResult      out  DATA_W  result to EX/MEM
//  writeData      out  DATA_W  forwarded B before the aluSrc mux (store data)
//  writeReg       out  5       destination register
//  zero           out  1       aluResult == 0
//  overflow       out  1       signed overflow on ADD/SUB
//  stall          out  1       1: hold PC, IF/ID and ID/EX
// BEHAVIOUR
//  aluOp: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed), 5 NOR, 6 XOR, 7 SLL, 8 SRL, 9 SRA,
//   10 LUI (B<<16), 11 MULT, 12 MULTU, 13 DIV (signed), 14 MFHI, 15 MFLO.
//  Shifts: operand = forwarded B, amount = immediate[10:6].
//  aluResult, writeData, writeReg, zero and overflow are combinational from current inputs.
//  ADD/SUB wrap modulo 2^32; overflow is a flag only, no trap, and the result is still produced.
//  overflow = 0 for every op except ADD/SUB.
//  Ops 11-13 set aluResult = 0; HI and LO change only through the muldiv FSM.
//  Muldiv FSM states: IDLE, BUSY, DONE; 5-bit step counter.
//   IDLE with aluOp in 11..13: stall=1 combinationally; latch operands; count=0; go to BUSY.
//   BUSY: one shift-add or restoring-divide step per cycle; stall=1.
//    When count==31, write HI/LO and go to DONE.
//   DONE: stall=0; ID/EX advances at this edge; return to IDLE, no restart even though the op is still present.
//  Latency: op present in cycle T -> stall high T..T+32; op retires at end of T+33; HI/LO valid from T+33.
//   Back-to-back muldiv ops restart normally. MFHI/MFLO immediately after need no forwarding.
//  MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product. Signed inputs: magnitudes are used, sign fixed at the end.
//  DIV: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
//   Divide by zero: HI = dividend, LO = 32'hFFFFFFFF; no trap; still takes 33 stall cycles.
//  Reset (any cycle, including mid-BUSY): state=IDLE, count=0, HI=LO=0, latched operands=0.
//   stall=0 in the cycle after reset unless a muldiv op is present.
//   All outputs follow their combinational definition using HI=LO=0.
//  Forwarding inputs are sampled only in IDLE; operands stay frozen during BUSY.
// CONFIGURATION
//  MULDIV_EN defined: HI/LO registers, FSM and ops 11-15 behave as above.
//  MULDIV_EN undefined: no HI/LO, FSM or counter; stall is tied to 0; ops 11-15 give aluResult = 0.
//   All other ops are unchanged.
// TESTING
//  ADD with data1=32'h7FFFFFFF, data2=1 -> aluResult=32'h80000000, overflow=1, zero=0.
//  SUB with forwardA=10, exMemResult=5, forwardB=01, memWbResult=5 -> aluResult=0, zero=1, writeData=5.
//  SRA with data2=32'h80000000, immediate[10:6]=4, aluSrc=0 -> aluResult=32'hF8000000.
//   Same op with regDst=1, rd=7 -> writeReg=7.
//  MULT with A=-3, B=7 -> stall high exactly 33 cycles, HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
//   MFLO in the next cycle -> aluResult=32'hFFFFFFEB.
//  DIV with A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
//   DIV with A=9, B=0 -> HI=9, LO=32'hFFFFFFFF, stall 33 cycles.
//  Reset in the 10th BUSY cycle with a non-muldiv op presented -> stall=0 next cycle; MFHI gives 0.
//   Rerun the MULT case without MULDIV_EN -> stall never asserts, aluResult=0.

Source files
------------

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX operand bundle into the execute stage and its EX/MEM-bound results
interface ex_stage_if #(
   parameter int DATA_W = 32
);
   logic [3:0]        aluOp;
   logic              regDst;
   logic              aluSrc;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;
   logic [DATA_W-1:0] immediate;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [1:0]        forwardA;
   logic [1:0]        forwardB;
   logic [DATA_W-1:0] exMemResult;
   logic [DATA_W-1:0] memWbResult;
   logic [DATA_W-1:0] aluResult;
   logic [DATA_W-1:0] writeData;
   logic [4:0]        writeReg;
   logic              zero;
   logic              overflow;
   logic              stall;

   modport master (
      output aluOp, regDst, aluSrc, data1, data2, immediate, rt, rd,
             forwardA, forwardB, exMemResult, memWbResult,
      input  aluResult, writeData, writeReg, zero, overflow, stall
   );

   modport slave (
      input  aluOp, regDst, aluSrc, data1, data2, immediate, rt, rd,
             forwardA, forwardB, exMemResult, memWbResult,
      output aluResult, writeData, writeReg, zero, overflow, stall
   );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: forwarding, ALU, HI/LO with iterative mul/div under MULDIV_EN
module ex_stage #(
   parameter int DATA_W = 32
) (
   input logic       clock,
   input logic       reset,
   ex_stage_if.slave ex
);
   localparam int MSB = DATA_W - 1;

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_SLT   = 4'd4;
   localparam logic [3:0] OP_NOR   = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_SLL   = 4'd7;
   localparam logic [3:0] OP_SRL   = 4'd8;
   localparam logic [3:0] OP_SRA   = 4'd9;
   localparam logic [3:0] OP_LUI   = 4'd10;
   localparam logic [3:0] OP_MULT  = 4'd11;
   localparam logic [3:0] OP_MULTU = 4'd12;
   localparam logic [3:0] OP_DIV   = 4'd13;
   localparam logic [3:0] OP_MFHI  = 4'd14;
   localparam logic [3:0] OP_MFLO  = 4'd15;

   logic [DATA_W-1:0] op_a, fwd_b, op_b;
   logic [DATA_W-1:0] add_res, sub_res, alu_res;
   logic [DATA_W-1:0] hi_val, lo_val;
   logic [4:0]        shamt;
   logic              ovf;

   always_comb begin
      case (ex.forwardA)
         2'b10:   op_a = ex.exMemResult;
         2'b01:   op_a = ex.memWbResult;
         default: op_a = ex.data1;
      endcase
      case (ex.forwardB)
         2'b10:   fwd_b = ex.exMemResult;
         2'b01:   fwd_b = ex.memWbResult;
         default: fwd_b = ex.data2;
      endcase
   end

   assign op_b    = ex.aluSrc ? ex.immediate : fwd_b;
   assign shamt   = ex.immediate[10:6];
   assign add_res = op_a + op_b;
   assign sub_res = op_a - op_b;

   always_comb begin
      alu_res = '0;
      ovf     = 1'b0;
      case (ex.aluOp)
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_ADD: begin
            alu_res = add_res;
            ovf     = (op_a[MSB] == op_b[MSB]) && (add_res[MSB] != op_a[MSB]);
         end
         OP_SUB: begin
            alu_res = sub_res;
            ovf     = (op_a[MSB] != op_b[MSB]) && (sub_res[MSB] != op_a[MSB]);
         end
         OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OP_NOR:  alu_res = ~(op_a | op_b);
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = fwd_b << shamt;
         OP_SRL:  alu_res = fwd_b >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(fwd_b) >>> shamt);
         OP_LUI:  alu_res = op_b << 16;
         OP_MFHI: alu_res = hi_val;
         OP_MFLO: alu_res = lo_val;
         default: alu_res = '0;
      endcase
   end

   assign ex.aluResult = alu_res;
   assign ex.writeData = fwd_b;
   assign ex.writeReg  = ex.regDst ? ex.rd : ex.rt;
   assign ex.zero      = (alu_res == '0);
   assign ex.overflow  = ovf;

`ifdef MULDIV_EN
   localparam int                CNT_W     = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

   md_state_t         state_q, state_d;
   logic [CNT_W-1:0]  count_q;
   logic [DATA_W-1:0] acc_q, shf_q, opa_q, hi_q, lo_q;
   logic              is_div_q, neg_res_q, neg_rem_q;

   logic              md_op, md_signed, a_neg, b_neg, start, md_stall;
   logic [DATA_W-1:0] mag_a, mag_b, acc_next, shf_next;
   logic [DATA_W:0]   mul_sum, div_shift, div_diff;
   logic [2*DATA_W-1:0] prod, prod_fix;
   logic [DATA_W-1:0] quo_fix, rem_fix;

   assign md_op     = (ex.aluOp == OP_MULT) || (ex.aluOp == OP_MULTU) || (ex.aluOp == OP_DIV);
   assign md_signed = (ex.aluOp == OP_MULT) || (ex.aluOp == OP_DIV);
   assign a_neg     = md_signed & op_a[MSB];
   assign b_neg     = md_signed & fwd_b[MSB];
   assign mag_a     = a_neg ? -op_a : op_a;
   assign mag_b     = b_neg ? -fwd_b : fwd_b;

   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      md_stall = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (md_op) begin
               start    = 1'b1;
               md_stall = 1'b1;
               state_d  = MD_BUSY;
            end
         end
         MD_BUSY: begin
            md_stall = 1'b1;
            if (count_q == LAST_STEP) state_d = MD_DONE;
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   // Multiply: {acc,shf} shifts right with the multiplier in shf.
   // Divide: {acc,shf} shifts left, shf collects quotient bits, acc is the partial remainder.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opa_q} : {(DATA_W+1){1'b0}});
      div_shift = {acc_q, shf_q[MSB]};
      div_diff  = div_shift - {1'b0, opa_q};
      if (is_div_q) begin
         if (!div_diff[DATA_W]) begin
            acc_next = div_diff[MSB:0];
            shf_next = {shf_q[MSB-1:0], 1'b1};
         end else begin
            acc_next = div_shift[MSB:0];
            shf_next = {shf_q[MSB-1:0], 1'b0};
         end
      end else begin
         acc_next = mul_sum[DATA_W:1];
         shf_next = {mul_sum[0], shf_q[MSB:1]};
      end
      prod     = {acc_next, shf_next};
      prod_fix = neg_res_q ? -prod : prod;
      quo_fix  = neg_res_q ? -shf_next : shf_next;
      rem_fix  = neg_rem_q ? -acc_next : acc_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= MD_IDLE;
         count_q   <= '0;
         acc_q     <= '0;
         shf_q     <= '0;
         opa_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start) begin
            count_q   <= '0;
            acc_q     <= '0;
            is_div_q  <= (ex.aluOp == OP_DIV);
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            shf_q     <= (ex.aluOp == OP_DIV) ? mag_a : mag_b;
            opa_q     <= (ex.aluOp == OP_DIV) ? mag_b : mag_a;
         end else if (state_q == MD_BUSY) begin
            count_q <= count_q + 1'b1;
            acc_q   <= acc_next;
            shf_q   <= shf_next;
            if (count_q == LAST_STEP) begin
               if (is_div_q) begin
                  // Zero divisor leaves the dividend magnitude in acc, so HI comes out as the dividend.
                  hi_q <= rem_fix;
                  lo_q <= (opa_q == '0) ? {DATA_W{1'b1}} : quo_fix;
               end else begin
                  hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                  lo_q <= prod_fix[MSB:0];
               end
            end
         end
      end
   end

   assign hi_val   = hi_q;
   assign lo_val   = lo_q;
   assign ex.stall = md_stall;
`else
   logic unused_clk_rst;

   assign unused_clk_rst = ^{clock, reset};
   assign hi_val         = '0;
   assign lo_val         = '0;
   assign ex.stall       = 1'b0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage: directed table, random ALU vs model, muldiv sequences
module tb_ex_stage;
   localparam int W = 32;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   ex_stage_if #(.DATA_W(W)) bus ();
   ex_stage #(.DATA_W(W)) dut (.clock(clock), .reset(reset), .ex(bus));

   typedef struct {
      logic [3:0]  op;
      logic        rdst;
      logic        asrc;
      logic [31:0] d1, d2, imm;
      logic [4:0]  rt, rd;
      logic [1:0]  fa, fb;
      logic [31:0] exm, mwb;
   } stim_t;

   typedef struct {
      logic [31:0] res, wd;
      logic [4:0]  wr;
      logic        z, ov;
   } resp_t;

   typedef struct {
      stim_t s;
      resp_t e;
   } vec_t;

   int          checks = 0;
   int          passed = 0;
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;
   vec_t        vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic stim_t mk_stim(input logic [3:0] op, input logic rdst, input logic asrc,
                                     input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [31:0] exm, input logic [31:0] mwb);
      stim_t s;
      s.op = op; s.rdst = rdst; s.asrc = asrc; s.d1 = d1; s.d2 = d2; s.imm = imm;
      s.rt = rt; s.rd = rd; s.fa = fa; s.fb = fb; s.exm = exm; s.mwb = mwb;
      return s;
   endfunction

   function automatic resp_t mk_resp(input logic [31:0] res, input logic [31:0] wd,
                                     input logic [4:0] wr, input logic z, input logic ov);
      resp_t e;
      e.res = res; e.wd = wd; e.wr = wr; e.z = z; e.ov = ov;
      return e;
   endfunction

   task automatic add_vec(input stim_t s, input resp_t e);
      vec_t v;
      v.s = s;
      v.e = e;
      vecs.push_back(v);
   endtask

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] exm, input logic [31:0] mwb);
      if (sel == 2'b10) return exm;
      if (sel == 2'b01) return mwb;
      return rf;
   endfunction

   // Reference ALU: signed arithmetic done in 64 bits so overflow is a plain range test.
   function automatic resp_t model(input stim_t s, input logic [31:0] hi, input logic [31:0] lo);
      resp_t       e;
      logic [31:0] a, fb, b, ones;
      longint      sa, sb, r;
      int          n;
      a    = pick(s.fa, s.d1, s.exm, s.mwb);
      fb   = pick(s.fb, s.d2, s.exm, s.mwb);
      b    = s.asrc ? s.imm : fb;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      n    = int'(s.imm[10:6]);
      ones = 32'hFFFFFFFF;
      e.res = '0;
      e.ov  = 1'b0;
      case (s.op)
         4'd0:  e.res = a & b;
         4'd1:  e.res = a | b;
         4'd2:  begin r = sa + sb; e.res = r[31:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
         4'd3:  begin r = sa - sb; e.res = r[31:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
         4'd4:  e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd5:  e.res = ~(a | b);
         4'd6:  e.res = a ^ b;
         4'd7:  e.res = fb << n;
         4'd8:  e.res = fb >> n;
         4'd9:  begin e.res = fb >> n; if (fb[31]) e.res = e.res | ~(ones >> n); end
         4'd10: e.res = b * 32'd65536;
         4'd14: e.res = hi;
         4'd15: e.res = lo;
         default: e.res = '0;
      endcase
      e.z  = (e.res == 32'd0);
      e.wd = fb;
      e.wr = s.rdst ? s.rd : s.rt;
      return e;
   endfunction

   task automatic drive(input stim_t s);
      bus.aluOp = s.op; bus.regDst = s.rdst; bus.aluSrc = s.asrc;
      bus.data1 = s.d1; bus.data2 = s.d2; bus.immediate = s.imm;
      bus.rt = s.rt; bus.rd = s.rd; bus.forwardA = s.fa; bus.forwardB = s.fb;
      bus.exMemResult = s.exm; bus.memWbResult = s.mwb;
   endtask

   task automatic check_resp(input string tag, input resp_t e);
      check({tag, ".res"},   bus.aluResult,        e.res);
      check({tag, ".wdata"}, bus.writeData,        e.wd);
      check({tag, ".wreg"},  32'(bus.writeReg),    32'(e.wr));
      check({tag, ".zero"},  32'(bus.zero),        32'(e.z));
      check({tag, ".ovf"},   32'(bus.overflow),    32'(e.ov));
      check({tag, ".stall"}, 32'(bus.stall),       32'd0);
   endtask

   task automatic apply(input string tag, input stim_t s, input resp_t e);
      @(posedge clock);
      #1 drive(s);
      @(negedge clock);
      check_resp(tag, e);
   endtask

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0: return 32'h00000000;
         1: return 32'h7FFFFFFF;
         2: return 32'h80000000;
         3: return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic random_alu(input int n, input string tag);
      stim_t s;
      int    op;
      for (int i = 0; i < n; i++) begin
         op = $urandom_range(0, 12);
         if (op >= 11) op = op + 3;
         s = mk_stim(4'(op), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     rnd_word(), rnd_word(), rnd_word(),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rnd_word(), rnd_word());
         apply($sformatf("%s%0d_op%0d", tag, i, op), s, model(s, mhi, mlo));
      end
   endtask

`ifdef MULDIV_EN
   task automatic run_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input bit readback);
      stim_t       s;
      int          cnt, bad;
      longint      p, q, r;
      logic [63:0] pu;
      logic [31:0] ehi, elo;
      string       tag;
      tag = $sformatf("md_op%0d_%h_%h", op, a, b);
      if (op == 4'd11) begin
         p = longint'($signed(a)) * longint'($signed(b));
         {ehi, elo} = p;
      end else if (op == 4'd12) begin
         pu = {32'd0, a} * {32'd0, b};
         {ehi, elo} = pu;
      end else if (b == 32'd0) begin
         ehi = a;
         elo = 32'hFFFFFFFF;
      end else begin
         q = longint'($signed(a)) / longint'($signed(b));
         r = longint'($signed(a)) % longint'($signed(b));
         elo = q[31:0];
         ehi = r[31:0];
      end
      s = mk_stim(op, 1'b0, 1'b0, a, b, 32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0);
      @(posedge clock);
      #1 drive(s);
      cnt = 0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (!bus.stall) break;
         if (bus.aluResult !== 32'd0) bad++;
         cnt++;
      end
      check({tag, ".stall_cycles"}, 32'(cnt), 32'd33);
      check({tag, ".res_nonzero_cycles"}, 32'(bad), 32'd0);
      mhi = ehi;
      mlo = elo;
      if (readback) begin
         s.op = 4'd14;
         apply({tag, ".mfhi"}, s, model(s, mhi, mlo));
         s.op = 4'd15;
         apply({tag, ".mflo"}, s, model(s, mhi, mlo));
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      stim_t s;
      int    cnt, bad;

      add_vec(mk_stim(4'd2, 0, 0, 32'h7FFFFFFF, 32'h1, 32'h0, 5'd3, 5'd9, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'h80000000, 32'h1, 5'd3, 0, 1));
      add_vec(mk_stim(4'd3, 0, 0, 32'h11, 32'h22, 32'h0, 5'd4, 5'd8, 2'b10, 2'b01, 32'h5, 32'h5),
              mk_resp(32'h0, 32'h5, 5'd4, 1, 0));
      add_vec(mk_stim(4'd9, 0, 0, 32'h0, 32'h80000000, 32'h100, 5'd2, 5'd7, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'hF8000000, 32'h80000000, 5'd2, 0, 0));
      add_vec(mk_stim(4'd9, 1, 0, 32'h0, 32'h80000000, 32'h100, 5'd2, 5'd7, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'hF8000000, 32'h80000000, 5'd7, 0, 0));
      add_vec(mk_stim(4'd10, 1, 1, 32'h0, 32'hDEAD, 32'h1234, 5'd1, 5'd12, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'h12340000, 32'hDEAD, 5'd12, 0, 0));
      add_vec(mk_stim(4'd4, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd5, 5'd6, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'h1, 32'h1, 5'd5, 0, 0));
      add_vec(mk_stim(4'd3, 0, 0, 32'h80000000, 32'h1, 32'h0, 5'd1, 5'd2, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'h7FFFFFFF, 32'h1, 5'd1, 0, 1));
      add_vec(mk_stim(4'd5, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'hFFFFFFFF, 32'h0, 5'd0, 0, 0));
      add_vec(mk_stim(4'd2, 0, 1, 32'h10, 32'hABC, 32'hFFFFFFFF, 5'd6, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'hF, 32'hABC, 5'd6, 0, 0));
      add_vec(mk_stim(4'd1, 0, 0, 32'hF0, 32'h0F, 32'h0, 5'd1, 5'd1, 2'b11, 2'b11, 32'h0F, 32'hF0),
              mk_resp(32'hFF, 32'h0F, 5'd1, 0, 0));
      add_vec(mk_stim(4'd8, 0, 0, 32'h0, 32'h80000000, 32'h7C0, 5'd3, 5'd4, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'h1, 32'h80000000, 5'd3, 0, 0));
      add_vec(mk_stim(4'd6, 0, 0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 5'd8, 5'd9, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'hF0F0F0F0, 32'h0FF00FF0, 5'd8, 0, 0));
      add_vec(mk_stim(4'd7, 0, 0, 32'h0, 32'h1, 32'h7C0, 5'd8, 5'd9, 2'b00, 2'b00, 32'h0, 32'h0),
              mk_resp(32'h80000000, 32'h1, 5'd8, 0, 0));

      reset = 1'b1;
      drive(mk_stim(4'd0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0));
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      s = mk_stim(4'd14, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0);
      apply("reset.mfhi", s, mk_resp(32'h0, 32'h0, 5'd0, 1, 0));
      s.op = 4'd15;
      apply("reset.mflo", s, mk_resp(32'h0, 32'h0, 5'd0, 1, 0));

      foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);

      random_alu(250, "rnd_a");

`ifdef MULDIV_EN
      run_muldiv(4'd11, 32'hFFFFFFFD, 32'd7, 1'b1);
      run_muldiv(4'd13, 32'hFFFFFFF9, 32'd2, 1'b1);
      run_muldiv(4'd13, 32'd9, 32'd0, 1'b1);
      run_muldiv(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      run_muldiv(4'd13, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      run_muldiv(4'd13, 32'd100, 32'hFFFFFFF9, 1'b0);
      run_muldiv(4'd11, 32'h80000000, 32'h80000000, 1'b1);
      for (int i = 0; i < 8; i++)
         run_muldiv(4'(11 + (i % 3)), rnd_word(), rnd_word(), 1'b1);

      random_alu(60, "rnd_b");

      s = mk_stim(4'd11, 0, 0, 32'd5, 32'd6, 32'h0, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0);
      @(posedge clock);
      #1 drive(s);
      repeat (10) @(posedge clock);
      #1 reset = 1'b1;
      s.op = 4'd2;
      drive(s);
      @(negedge clock);
      check("rst_busy.stall_before_edge", 32'(bus.stall), 32'd1);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_busy.stall_after", 32'(bus.stall), 32'd0);
      check("rst_busy.add_res", bus.aluResult, 32'd11);
      mhi = '0;
      mlo = '0;
      s.op = 4'd14;
      apply("rst_busy.mfhi", s, model(s, mhi, mlo));
      s.op = 4'd15;
      apply("rst_busy.mflo", s, model(s, mhi, mlo));
`else
      s = mk_stim(4'd11, 0, 0, 32'hFFFFFFFD, 32'd7, 32'h0, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0);
      @(posedge clock);
      #1 drive(s);
      cnt = 0;
      bad = 0;
      repeat (40) begin
         @(negedge clock);
         if (bus.stall) cnt++;
         if (bus.aluResult !== 32'd0) bad++;
      end
      check("nomd.stall_cycles", 32'(cnt), 32'd0);
      check("nomd.res_nonzero_cycles", 32'(bad), 32'd0);
      s.op = 4'd14;
      apply("nomd.mfhi", s, mk_resp(32'h0, 32'd7, 5'd0, 1, 0));
      s.op = 4'd15;
      apply("nomd.mflo", s, mk_resp(32'h0, 32'd7, 5'd0, 1, 0));
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
